// File: rtl/add_pkg.sv
// Shared constants, operand bundle and requester-id helpers for the arbitrated adder.
package add_pkg;

    localparam int ADD_W = 8;
    localparam int LAT   = 2;

    typedef struct packed {
        logic [ADD_W-1:0] a;
        logic [ADD_W-1:0] b;
        logic             cin;
    } add_op_t;

    // Requester-id width; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int next_id(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

    // Requester examined at search offset k when the search starts at ptr.
    function automatic int rr_index(input int ptr, input int k, input int n);
        int s;
        s = ptr + k;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/add8_pipe.sv
// Two-stage 8-bit adder: low nibble plus carry-in first, high nibble plus nibble carry second.
module add8_pipe
    import add_pkg::*;
(
    input  logic             clk,
    input  logic [ADD_W-1:0] a,
    input  logic [ADD_W-1:0] b,
    input  logic             cin,
    output logic [ADD_W-1:0] sum,
    output logic             cout
);

    localparam int HALF = ADD_W / 2;

    logic [HALF:0]    lo_reg;
    logic [HALF-1:0]  a_hi_reg;
    logic [HALF-1:0]  b_hi_reg;
    logic [HALF:0]    hi_next;
    logic [ADD_W-1:0] sum_reg;
    logic             cout_reg;

    assign hi_next = {1'b0, a_hi_reg} + {1'b0, b_hi_reg} + {{HALF{1'b0}}, lo_reg[HALF]};

    // Datapath only: validity is tracked by the caller, so no reset is needed here.
    always_ff @(posedge clk) begin
        lo_reg   <= {1'b0, a[HALF-1:0]} + {1'b0, b[HALF-1:0]} + {{HALF{1'b0}}, cin};
        a_hi_reg <= a[ADD_W-1:HALF];
        b_hi_reg <= b[ADD_W-1:HALF];
        sum_reg  <= {hi_next[HALF-1:0], lo_reg[HALF-1:0]};
        cout_reg <= hi_next[HALF];
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter feeding a shared two-stage adder; results return in grant order.
module add_arbiter
    import add_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*ADD_W-1:0] op_a,
    input  logic [N_REQ*ADD_W-1:0] op_b,
    input  logic [N_REQ-1:0]       op_cin,
    output logic [N_REQ-1:0]       gnt,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [ADD_W-1:0]       rsp_sum,
    output logic                   rsp_cout,
    output logic                   busy,
    output logic [15:0]            issue_cnt
);

    add_op_t          lane_op [N_REQ];
    add_op_t          op_sel;
    logic [N_REQ-1:0] gnt_next;
    logic [ID_W-1:0]  gnt_id;
    logic             accept;
    logic [ID_W-1:0]  ptr_reg;
    logic [LAT-1:0]   vld_reg;
    logic [ID_W-1:0]  id_reg [LAT];
    logic [15:0]      cnt_reg;
    logic [ADD_W-1:0] sum_pipe;
    logic             cout_pipe;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign lane_op[gi] = {op_a[gi*ADD_W +: ADD_W], op_b[gi*ADD_W +: ADD_W], op_cin[gi]};
        end
    endgenerate

    // First requesting lane at or after the pointer wins; rst_n gating keeps gnt low in reset.
    always_comb begin
        gnt_next = '0;
        gnt_id   = '0;
        accept   = 1'b0;
        op_sel   = '0;
        if (en && rst_n) begin
            for (int k = 0; k < N_REQ; k++) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (!accept && req[i] && rr_index(int'(ptr_reg), k, N_REQ) == i) begin
                        accept      = 1'b1;
                        gnt_next[i] = 1'b1;
                        gnt_id      = ID_W'(i);
                        op_sel      = lane_op[i];
                    end
                end
            end
        end
    end

    add8_pipe u_add (
        .clk  (clk),
        .a    (op_sel.a),
        .b    (op_sel.b),
        .cin  (op_sel.cin),
        .sum  (sum_pipe),
        .cout (cout_pipe)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
            vld_reg <= '0;
            cnt_reg <= '0;
            for (int s = 0; s < LAT; s++) begin
                id_reg[s] <= '0;
            end
        end else begin
            vld_reg   <= {vld_reg[LAT-2:0], accept};
            id_reg[0] <= gnt_id;
            for (int s = 1; s < LAT; s++) begin
                id_reg[s] <= id_reg[s-1];
            end
            if (accept) begin
                ptr_reg <= ID_W'(next_id(int'(gnt_id), N_REQ));
                cnt_reg <= cnt_reg + 16'd1;
            end
        end
    end

    assign gnt       = gnt_next;
    assign rsp_valid = vld_reg[LAT-1];
    assign rsp_id    = rsp_valid ? id_reg[LAT-1] : '0;
    assign rsp_sum   = rsp_valid ? sum_pipe : '0;
    assign rsp_cout  = rsp_valid ? cout_pipe : 1'b0;
    assign busy      = (|req) || (|vld_reg);
    assign issue_cnt = cnt_reg;

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter: single ops, round-robin stream, enable gating, reset flush, counter wrap.
module tb_add_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [N-1:0]   req;
    logic [N*8-1:0] op_a;
    logic [N*8-1:0] op_b;
    logic [N-1:0]   op_cin;
    logic [N-1:0]   gnt;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [7:0]     rsp_sum;
    logic           rsp_cout;
    logic           busy;
    logic [15:0]    issue_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_sum [4] = '{8'h01, 8'h12, 8'h23, 8'h34};

    add_arbiter #(.N_REQ(N), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_cin    (op_cin),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .busy      (busy),
        .issue_cnt (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("check %s = 0x%0h at %0t", tag, got, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic [7:0] a, input logic [7:0] b, input logic c);
        op_a[8*i +: 8] = a;
        op_b[8*i +: 8] = b;
        op_cin[i]      = c;
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b1;
        req    = '1;
        op_a   = '0;
        op_b   = '0;
        op_cin = '0;

        // Reset state with requests pending
        #12;
        check_eq("rst_gnt", 32'(gnt), 32'h0);
        check_eq("rst_valid", 32'(rsp_valid), 32'h0);
        check_eq("rst_sum", 32'(rsp_sum), 32'h0);
        check_eq("rst_cnt", 32'(issue_cnt), 32'h0);
        step();
        step();
        req   = '0;
        rst_n = 1'b1;
        step();

        // Single op on requester 0
        set_lane(0, 8'h0F, 8'h01, 1'b0);
        req = 4'b0001;
        #1;
        check_eq("t1_gnt", 32'(gnt), 32'h1);
        check_eq("t1_busy", 32'(busy), 32'h1);
        step();
        req = '0;
        check_eq("t1_lat1_valid", 32'(rsp_valid), 32'h0);
        step();
        check_eq("t1_valid", 32'(rsp_valid), 32'h1);
        check_eq("t1_id", 32'(rsp_id), 32'h0);
        check_eq("t1_sum", 32'(rsp_sum), 32'h10);
        check_eq("t1_cout", 32'(rsp_cout), 32'h0);
        check_eq("t1_cnt", 32'(issue_cnt), 32'h1);
        step();
        check_eq("t1_after_valid", 32'(rsp_valid), 32'h0);
        check_eq("t1_after_sum", 32'(rsp_sum), 32'h0);

        // Requester 2 with full carry chain
        set_lane(2, 8'hFF, 8'h01, 1'b1);
        req = 4'b0100;
        #1;
        check_eq("t2_gnt", 32'(gnt), 32'h4);
        step();
        req = '0;
        step();
        check_eq("t2_valid", 32'(rsp_valid), 32'h1);
        check_eq("t2_id", 32'(rsp_id), 32'h2);
        check_eq("t2_sum", 32'(rsp_sum), 32'h01);
        check_eq("t2_cout", 32'(rsp_cout), 32'h1);
        step();
        check_eq("t2_idle_busy", 32'(busy), 32'h0);

        // All four requesting for 8 cycles, pointer back at 0
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        check_eq("t3_cnt_clr", 32'(issue_cnt), 32'h0);
        for (int i = 0; i < N; i++) begin
            set_lane(i, 8'(16 * i + 1), 8'(i), 1'b0);
        end
        for (int c = 0; c < 11; c++) begin
            req = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (c < 8) begin
                check_eq($sformatf("t3_gnt_%0d", c), 32'(gnt), 32'(1 << (c % 4)));
            end
            check_eq($sformatf("t3_valid_%0d", c), 32'(rsp_valid), 32'((c >= 2 && c <= 9) ? 1 : 0));
            if (c >= 2 && c <= 9) begin
                check_eq($sformatf("t3_id_%0d", c), 32'(rsp_id), 32'((c - 2) % 4));
                check_eq($sformatf("t3_sum_%0d", c), 32'(rsp_sum), 32'(exp_sum[(c - 2) % 4]));
            end
            step();
        end
        check_eq("t3_cnt", 32'(issue_cnt), 32'h8);

        // en drops after two grants with 0110 still requesting
        req = 4'b0110;
        #1;
        check_eq("t4_gnt0", 32'(gnt), 32'h2);
        step();
        #1;
        check_eq("t4_gnt1", 32'(gnt), 32'h4);
        step();
        en = 1'b0;
        #1;
        check_eq("t4_blk0", 32'(gnt), 32'h0);
        check_eq("t4_rsp0_valid", 32'(rsp_valid), 32'h1);
        check_eq("t4_rsp0_id", 32'(rsp_id), 32'h1);
        check_eq("t4_rsp0_sum", 32'(rsp_sum), 32'h12);
        step();
        check_eq("t4_blk1", 32'(gnt), 32'h0);
        check_eq("t4_rsp1_valid", 32'(rsp_valid), 32'h1);
        check_eq("t4_rsp1_id", 32'(rsp_id), 32'h2);
        check_eq("t4_rsp1_sum", 32'(rsp_sum), 32'h23);
        step();
        check_eq("t4_blk2", 32'(gnt), 32'h0);
        check_eq("t4_drain_valid", 32'(rsp_valid), 32'h0);
        check_eq("t4_busy", 32'(busy), 32'h1);
        step();
        en = 1'b1;
        #1;
        check_eq("t4_resume_gnt", 32'(gnt), 32'h2);
        step();
        req = '0;
        step();
        check_eq("t4_resume_id", 32'(rsp_id), 32'h1);
        step();

        // Reset one cycle after two grants: in-flight ops discarded
        req = 4'b1111;
        step();
        step();
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_valid", 32'(rsp_valid), 32'h0);
        check_eq("t5_rst_gnt", 32'(gnt), 32'h0);
        check_eq("t5_rst_id", 32'(rsp_id), 32'h0);
        check_eq("t5_rst_cnt", 32'(issue_cnt), 32'h0);
        step();
        check_eq("t5_rst_valid2", 32'(rsp_valid), 32'h0);
        req   = 4'b1100;
        rst_n = 1'b1;
        #1;
        check_eq("t5_rel_gnt", 32'(gnt), 32'h4);
        check_eq("t5_rel_valid", 32'(rsp_valid), 32'h0);
        step();
        req = '0;
        check_eq("t5_rel_valid2", 32'(rsp_valid), 32'h0);
        step();
        check_eq("t5_new_valid", 32'(rsp_valid), 32'h1);
        check_eq("t5_new_id", 32'(rsp_id), 32'h2);
        step();

        // issue_cnt wrap: 65535 accepts then one more
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req   = 4'b0001;
        for (int i = 0; i < 65535; i++) begin
            step();
        end
        check_eq("t6_cnt_max", 32'(issue_cnt), 32'hFFFF);
        step();
        check_eq("t6_cnt_wrap", 32'(issue_cnt), 32'h0);
        req = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
